johnson_phase_sequencer: RTL and testbench

Controller that sequences an 8-stage Johnson counter through a requested number of steps under a start/done handshake, with pause (hold) and clear control. It owns the Johnson state register and publishes the raw state plus a decoded phase index (0..15) to downstream phase-driven logic. It sits between a job issuer and any consumer of multiphase timing.

---
 rtl/jc_seq_pkg.sv | 47 ++++
 rtl/johnson_counter_core.sv | 64 ++++++
 rtl/johnson_phase_sequencer.sv | 95 +++++++++
 tb/tb_johnson_phase_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jc_seq_pkg.sv
// Shared types and helpers for the Johnson phase sequencer: FSM state enum,
// phase width, phase decode and legal-code check (generic over register width).
package jc_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} seq_state_t;

  localparam int JC_WIDTH = 8;
  localparam int PHASE_W  = $clog2(2 * JC_WIDTH);

  function automatic int jc_popcount(logic [31:0] code, int width);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < width && code[i]) n++;
    end
    return n;
  endfunction

  // Rising half of the cycle ends in 1 (phase = ones count); falling half
  // ends in 0 and counts down from 2*width.
  function automatic int jc_phase(logic [31:0] code, int width);
    int n;
    n = jc_popcount(code, width);
    if (code[0])     return n;
    else if (n == 0) return 0;
    else             return 2 * width - n;
  endfunction

  // Legal codes are a run of ones anchored at bit 0 or at bit width-1.
  function automatic logic jc_is_legal(logic [31:0] code, int width);
    logic [31:0] full;
    logic [31:0] low;
    logic [31:0] c;
    logic        ok;
    full = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    c    = code & full;
    ok   = 1'b0;
    for (int p = 0; p <= 32; p++) begin
      if (p <= width) begin
        low = (p >= 32) ? '1 : ((32'd1 << p) - 32'd1);
        if (c == low || c == (full & ~low)) ok = 1'b1;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/johnson_counter_core.sv
// Johnson register with advance/clear, phase decode and, when
// JC_ILLEGAL_RECOVER_EN is defined, recovery of illegal codes to zero.
import jc_seq_pkg::*;

module johnson_counter_core #(
  parameter int  WIDTH = JC_WIDTH,
  localparam int PW    = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             clear,
  output logic [WIDTH-1:0] jc_state,
  output logic [PW-1:0]    phase,
  output logic             err
);

  logic [WIDTH-1:0] jc_q;
  logic [PW-1:0]    phase_raw;

  assign phase_raw = PW'(jc_phase(32'(jc_q), WIDTH));
  assign jc_state  = jc_q;

`ifdef JC_ILLEGAL_RECOVER_EN
  logic legal;
  logic err_q;

  assign legal = jc_is_legal(32'(jc_q), WIDTH);
  assign phase = legal ? phase_raw : '0;
  assign err   = err_q;

  // Recovery overrides clear/advance and ignores the sequencer's FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      jc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (!legal) begin
        jc_q  <= '0;
        err_q <= 1'b1;
      end else if (clear) begin
        jc_q <= '0;
      end else if (advance) begin
        jc_q <= {jc_q[WIDTH-2:0], ~jc_q[WIDTH-1]};
      end
    end
  end
`else
  assign phase = phase_raw;
  assign err   = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      jc_q <= '0;
    end else if (clear) begin
      jc_q <= '0;
    end else if (advance) begin
      jc_q <= {jc_q[WIDTH-2:0], ~jc_q[WIDTH-1]};
    end
  end
`endif

endmodule

// File: rtl/johnson_phase_sequencer.sv
// Start/done sequencer stepping a Johnson counter a requested number of times,
// with hold and clear. Optional illegal-code recovery: JC_ILLEGAL_RECOVER_EN.
import jc_seq_pkg::*;

module johnson_phase_sequencer #(
  parameter int  WIDTH = JC_WIDTH,
  parameter int  CNT_W = 8,
  localparam int PW    = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] steps,
  input  logic             hold,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] jc_state,
  output logic [PW-1:0]    phase,
  output logic             err,
  output seq_state_t       fsm_state
);

  // Handshake: start/steps are sampled on any edge where the FSM is IDLE and
  // clear is low; done pulses one cycle per accepted job; busy covers RUN/PAUSE.
  seq_state_t       state;
  logic [CNT_W-1:0] remaining;
  logic             advance;
  logic             core_clear;

  assign advance    = (state == RUN) && !hold;
  assign core_clear = (state == IDLE) && clear;
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (!clear && start) begin
            if (steps != '0) begin
              state     <= RUN;
              remaining <= steps;
              busy      <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hold) begin
            state <= PAUSE;
          end else begin
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        PAUSE: begin
          // Resuming costs one edge with no advance.
          if (!hold) state <= RUN;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  johnson_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .advance  (advance),
    .clear    (core_clear),
    .jc_state (jc_state),
    .phase    (phase),
    .err      (err)
  );

endmodule

// File: tb/tb_johnson_phase_sequencer.sv
// Directed bench for johnson_phase_sequencer; also covers the
// JC_ILLEGAL_RECOVER_EN build when that macro is defined.
import jc_seq_pkg::*;

module tb_johnson_phase_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] steps;
  logic       hold;
  logic       clear;
  logic       busy;
  logic       done;
  logic [7:0] jc_state;
  logic [3:0] phase;
  logic       err;
  seq_state_t fsm_state;

  int n_checks;
  int n_fail;
  logic [31:0] exp_q[$];

  johnson_phase_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .steps     (steps),
    .hold      (hold),
    .clear     (clear),
    .busy      (busy),
    .done      (done),
    .jc_state  (jc_state),
    .phase     (phase),
    .err       (err),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change only at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_job(input logic [7:0] n);
    start = 1'b1;
    steps = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic finish_job(input string tag);
    start = 1'b0;
    tick();
    check({tag, "_done_low"}, 32'(done), 0);
    check({tag, "_idle"}, 32'(fsm_state), 32'(IDLE));
  endtask

  task automatic clear_state();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int lat;
    int bc;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    start = 1'b0;
    steps = '0;
    hold  = 1'b0;
    clear = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_jc", 32'(jc_state), 0);
    check("rst_phase", 32'(phase), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    reset = 1'b1;
    tick();

    // five steps from zero
    start_job(8'd5);
    wait_done(lat, bc);
    check("s5_latency", 32'(lat), 5);
    check("s5_busy_cycles", 32'(bc), 5);
    check("s5_jc", 32'(jc_state), 32'b00011111);
    check("s5_phase", 32'(phase), 5);
    check("s5_busy_low", 32'(busy), 0);
    finish_job("s5");

    // full revolution, phase walks 1..15 then 0
    clear_state();
    check("clr_jc", 32'(jc_state), 0);
    for (int i = 1; i < 16; i++) exp_q.push_back(32'(i));
    exp_q.push_back(32'd0);
    start_job(8'd16);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("s16_phase", 32'(phase), exp_q.pop_front());
    end
    check("s16_done", 32'(done), 1);
    check("s16_jc", 32'(jc_state), 0);
    finish_job("s16");

    // nine steps: first code of the falling half
    start_job(8'd9);
    wait_done(lat, bc);
    check("s9_latency", 32'(lat), 9);
    check("s9_jc", 32'(jc_state), 32'b11111110);
    check("s9_phase", 32'(phase), 9);
    finish_job("s9");

    // four steps with hold high for 3 cycles after the 2nd advance
    clear_state();
    start_job(8'd4);
    tick();
    tick();
    check("hold_jc2", 32'(jc_state), 32'b00000011);
    hold = 1'b1;
    repeat (3) tick();
    check("hold_paused", 32'(fsm_state), 32'(PAUSE));
    check("hold_busy", 32'(busy), 1);
    check("hold_jc_frozen", 32'(jc_state), 32'b00000011);
    hold = 1'b0;
    tick();
    tick();
    check("hold_not_done", 32'(done), 0);
    check("hold_jc3", 32'(jc_state), 32'b00000111);
    tick();
    check("hold_done", 32'(done), 1);
    check("hold_jc", 32'(jc_state), 32'b00001111);
    finish_job("hold");

    // zero-step job
    start_job(8'd0);
    check("s0_done", 32'(done), 1);
    check("s0_busy", 32'(busy), 0);
    check("s0_jc", 32'(jc_state), 32'b00001111);
    finish_job("s0");

    // start held high during a job must not add advances
    start_job(8'd3);
    start = 1'b1;
    steps = 8'd7;
    wait_done(lat, bc);
    check("ign_latency", 32'(lat), 3);
    check("ign_jc", 32'(jc_state), 32'b01111111);
    finish_job("ign");
    tick();
    check("ign_no_restart", 32'(busy), 0);

    // reset in the middle of a ten-step job
    start_job(8'd10);
    repeat (3) tick();
    check("mid_jc", 32'(jc_state), 32'b11111100);
    reset = 1'b0;
    #1;
    check("mid_rst_jc", 32'(jc_state), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_phase", 32'(phase), 0);
    check("mid_rst_state", 32'(fsm_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    tick();

    // clear beats start in IDLE
    start_job(8'd2);
    wait_done(lat, bc);
    finish_job("pre_clr");
    check("pre_clr_jc", 32'(jc_state), 32'b00000011);
    clear = 1'b1;
    start = 1'b1;
    steps = 8'd5;
    tick();
    clear = 1'b0;
    start = 1'b0;
    check("clr_start_jc", 32'(jc_state), 0);
    check("clr_start_busy", 32'(busy), 0);
    tick();
    check("clr_start_busy2", 32'(busy), 0);
    check("clr_start_done", 32'(done), 0);

    // illegal code injected mid-job
    start_job(8'd3);
    tick();
    check("ill_jc1", 32'(jc_state), 32'b00000001);
    force dut.u_core.jc_q = 8'b00000101;
    #1;
    release dut.u_core.jc_q;
    tick();
`ifdef JC_ILLEGAL_RECOVER_EN
    check("ill_jc_recover", 32'(jc_state), 0);
    check("ill_err", 32'(err), 1);
    tick();
    check("ill_err_pulse", 32'(err), 0);
    check("ill_jc_after", 32'(jc_state), 32'b00000001);
`else
    check("ill_jc_shift", 32'(jc_state), 32'b00001011);
    check("ill_err", 32'(err), 0);
    tick();
    check("ill_err_later", 32'(err), 0);
    check("ill_jc_after", 32'(jc_state), 32'b00010111);
`endif
    check("ill_done", 32'(done), 1);
    finish_job("ill");

    // report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
